step_sequencer: RTL

Controller that sequences the two sequence-detector FSMs (binary- and one-hot-encoded) on the board. It replaces the raw button-as-clock arrangement: all logic runs on the system clock, and the block issues a single-cycle `step` clock-enable plus a registered `w` bit to both FSMs. Steps come from a debounced manual button press or from replay of a fixed test pattern. An optional checker compares the two FSMs' `z` outputs after every step.

---
 rtl/step_seq_pkg.sv | 8 +
 rtl/step_sequencer_debouncer.sv | 29 ++
 rtl/step_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/step_seq_pkg.sv
// step_seq_pkg: shared state encoding, step counter width and counter-width helper
package step_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PULSE, REPLAY} state_t;
  localparam int STEP_CNT_W = 8;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/step_sequencer_debouncer.sv
// debouncer: 2-FF synchronizer, stability counter, clean level and one-cycle rising-edge press
import step_seq_pkg::*;
module debouncer #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic Reset,
  input  logic in,
  output logic level,
  output logic press
);
  localparam int CW = cnt_w(DEB_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  // accept a new level only after DEB_CYCLES consecutive cycles of the synchronized value
  always_ff @(posedge clk or posedge Reset)
    if (Reset) {sync, cnt, level, level_d} <= '0;
    else begin
      sync <= {sync[0], in};
      level_d <= level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  assign press = level & ~level_d;
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: issues debounced manual or pattern-replay steps to both FSMs; STEP_CHECK_EN adds the z checker
import step_seq_pkg::*;
module step_sequencer #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int TICK_DIV = 50_000_000,
  parameter int PAT_LEN = 8,
  parameter logic [31:0] PATTERN = 32'h0000_000F
) (
  input  logic clk,
  input  logic Reset,
  input  logic btn,
  input  logic sw,
  input  logic mode,
  input  logic z_bin,
  input  logic z_onehot,
  output logic step,
  output logic w,
  output logic busy,
  output logic [STEP_CNT_W-1:0] step_cnt,
  output logic mismatch
);
  localparam int TW = cnt_w(TICK_DIV);
  localparam int IW = cnt_w(PAT_LEN);
  state_t state;
  logic [TW-1:0] tick;
  logic [IW-1:0] idx;
  logic [31:0] sr;
  logic press, tick_hit, last, unused_level;
  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk),
    .Reset(Reset),
    .in(btn),
    .level(unused_level),
    .press(press)
  );
  assign tick_hit = tick == TW'(TICK_DIV - 1);
  assign last = idx == IW'(PAT_LEN - 1);
  assign step = (state == PULSE) || (state == REPLAY && tick_hit);
  assign busy = state != IDLE;
  // sequencing FSM; sr holds the not-yet-sent pattern bits MSB-first
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      w <= 1'b0;
      tick <= '0;
      idx <= '0;
      sr <= '0;
    end else
      case (state)
        IDLE:
          if (press) begin
            if (mode) begin
              state <= REPLAY;
              w <= PATTERN[PAT_LEN-1];
              sr <= PATTERN << (33 - PAT_LEN);
              idx <= '0;
              tick <= '0;
            end else state <= LOAD;
          end
        LOAD: begin
          w <= sw;
          state <= PULSE;
        end
        PULSE: state <= IDLE;
        default: begin
          tick <= tick_hit ? '0 : tick + 1'b1;
          if (tick_hit) begin
            if (last) state <= IDLE;
            else begin
              idx <= idx + 1'b1;
              w <= sr[31];
              sr <= sr << 1;
            end
          end
        end
      endcase
  // count issued steps, visible the cycle after each step
  always_ff @(posedge clk or posedge Reset)
    if (Reset) step_cnt <= '0;
    else step_cnt <= step_cnt + STEP_CNT_W'(step);
`ifdef STEP_CHECK_EN
  logic [1:0] step_d;
  // compare the FSM outputs two cycles after each step and latch any disagreement
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      step_d <= '0;
      mismatch <= 1'b0;
    end else begin
      step_d <= {step_d[0], step};
      if (step_d[1] && (z_bin != z_onehot)) mismatch <= 1'b1;
    end
`else
  logic unused_z;
  assign unused_z = z_bin ^ z_onehot;
  assign mismatch = 1'b0;
`endif
endmodule
